addr_pair_sweeper: RTL

//  Parametrised multi-lane address sweep generator for dual/multi-port memory

---
 rtl/addr_pair_sweeper.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/addr_pair_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : addr_pair_sweeper
// Purpose  : Multi-lane address sweep generator with valid/ready handshake.
//            Each beat carries LANES adjacent addresses {idx, lane}.
// Revision : 1.0 - initial release
// ============================================================================
module addr_pair_sweeper #(
    parameter  int ADDR_W = 14,
    parameter  int LANES  = 2,
    localparam int LANE_W = $clog2(LANES),
    localparam int IDX_W  = ADDR_W - LANE_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_i,
    input  logic [IDX_W-1:0]          first_idx_i,
    input  logic [IDX_W-1:0]          last_idx_i,
    input  logic                      loop_mode_i,
    input  logic                      abort_i,
    input  logic                      ready_i,
    output logic                      valid_o,
    output logic [LANES*ADDR_W-1:0]   addr_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      cfg_err_o,
    output logic [IDX_W:0]            beat_count_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] first_q, first_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             loop_q, loop_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic             cfg_err_q, cfg_err_d;

    logic w_xfer;
    logic w_at_last;
    logic w_cfg_ok;

    assign w_xfer    = (state_q == S_RUN) && ready_i;
    assign w_at_last = (idx_q == last_q);
    assign w_cfg_ok  = (first_idx_i <= last_idx_i);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks the end-of-sweep transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && w_cfg_ok) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (w_xfer && w_at_last && !loop_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        valid_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            S_RUN: begin
                valid_o = 1'b1;
                busy_o  = 1'b1;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state; the compare precedes the increment, so a last
    // index of all-ones never wraps through zero.
    always_comb begin
        idx_d     = idx_q;
        first_d   = first_q;
        last_d    = last_q;
        loop_d    = loop_q;
        cnt_d     = cnt_q;
        cfg_err_d = 1'b0;
        if (state_q == S_IDLE && start_i) begin
            if (w_cfg_ok) begin
                first_d = first_idx_i;
                last_d  = last_idx_i;
                loop_d  = loop_mode_i;
                idx_d   = first_idx_i;
                cnt_d   = '0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (w_xfer) begin
            if (!(&cnt_q)) begin
                cnt_d = cnt_q + {{IDX_W{1'b0}}, 1'b1};
            end
            if (!w_at_last) begin
                idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
            end else if (loop_q) begin
                idx_d = first_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q     <= '0;
            first_q   <= '0;
            last_q    <= '0;
            loop_q    <= 1'b0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            first_q   <= first_d;
            last_q    <= last_d;
            loop_q    <= loop_d;
            cnt_q     <= cnt_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err_o    = cfg_err_q;
    assign beat_count_o = cnt_q;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            assign addr_o[k*ADDR_W +: ADDR_W] = {idx_q, LANE_W'(k)};
        end
    endgenerate

endmodule
`default_nettype wire
